// File: rtl/control_puertas.sv
// Elevator cabin door controller: opens at a served floor, holds, closes, and
// blocks car motion while the door is not closed.
//
// state    | meaning
// ---------+--------------------------------------------------
// CERRADA  | door closed, car free to move unless opening now
// ABRIENDO | door motor opening for T_MOV cycles
// ABIERTA  | door open, hold timer T_ABIERTA, floor requests absorbed
// CERRANDO | door motor closing for T_MOV cycles, reopen on obstacle
module control_puertas #(
  parameter int T_MOV     = 3,
  parameter int T_ABIERTA = 5,
  parameter int CW        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] estado,
  input  logic [9:0] s,
  input  logic       boton_abrir,
  input  logic       boton_cerrar,
  input  logic       obstaculo,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       esperar,
  output logic [9:0] limpiar,
  output logic       falla
);

  typedef enum logic [1:0] {
    CERRADA  = 2'd0,
    ABRIENDO = 2'd1,
    ABIERTA  = 2'd2,
    CERRANDO = 2'd3
  } estado_puerta_t;

  localparam logic [CW-1:0] CARGA_MOV     = CW'(T_MOV - 1);
  localparam logic [CW-1:0] CARGA_ABIERTA = CW'(T_ABIERTA - 1);

  estado_puerta_t state_q, state_d;
  logic [CW-1:0]  t_q, t_d;
  logic           motor_abrir_q, motor_abrir_d;
  logic           motor_cerrar_q, motor_cerrar_d;
  logic           falla_q, falla_d;

  logic [9:0] mascara;
  logic       pedido_piso;
  logic       abre;
  logic       t_cero;
  logic       unused_dir;

  // Travel direction does not affect the door.
  assign unused_dir = estado[2];

  always_comb begin
    mascara = 10'h000;
    case (estado[1:0])
      2'd0:    mascara = 10'h041;
      2'd1:    mascara = 10'h086;
      2'd2:    mascara = 10'h118;
      default: mascara = 10'h220;
    endcase
  end

  assign pedido_piso = |(s & mascara);
  assign abre        = !estado[3] && (pedido_piso || boton_abrir);
  assign t_cero      = (t_q == '0);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      CERRADA: begin
        if (abre) begin
          state_d = ABRIENDO;
          t_d     = CARGA_MOV;
        end
      end
      ABRIENDO: begin
        if (t_cero) begin
          state_d = ABIERTA;
          t_d     = CARGA_ABIERTA;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
      ABIERTA: begin
        // Anything asking for the door outranks the close button.
        if (obstaculo || boton_abrir || pedido_piso) begin
          t_d = CARGA_ABIERTA;
        end else if (boton_cerrar || t_cero) begin
          state_d = CERRANDO;
          t_d     = CARGA_MOV;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
      default: begin
        if (obstaculo || boton_abrir) begin
          state_d = ABRIENDO;
          t_d     = CARGA_MOV;
        end else if (t_cero) begin
          state_d = CERRADA;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
    endcase

    motor_abrir_d  = (state_d == ABRIENDO);
    motor_cerrar_d = (state_d == CERRANDO);
    falla_d        = falla_q || (estado[3] && (state_q != CERRADA));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= CERRANDO;
      t_q            <= CARGA_MOV;
      motor_abrir_q  <= 1'b0;
      motor_cerrar_q <= 1'b1;
      falla_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      motor_abrir_q  <= motor_abrir_d;
      motor_cerrar_q <= motor_cerrar_d;
      falla_q        <= falla_d;
    end
  end

  assign motor_abrir  = motor_abrir_q;
  assign motor_cerrar = motor_cerrar_q;
  assign falla        = falla_q;
  assign esperar      = (state_q != CERRADA) || abre;
  assign limpiar      = (state_q == ABIERTA) ? (s & mascara) : 10'h000;

endmodule

// File: tb/tb_control_puertas.sv
// Directed bench for control_puertas: per-cycle vector table for the basic
// open/close cycles, plus hand sequences for reload, reopen, moving and fault.
module tb_control_puertas;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] estado;
  logic [9:0] s;
  logic       boton_abrir, boton_cerrar, obstaculo;
  logic       motor_abrir, motor_cerrar, esperar, falla;
  logic [9:0] limpiar;

  int n_tests = 0;
  int n_fail  = 0;

  control_puertas #(.T_MOV(3), .T_ABIERTA(5), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .estado(estado), .s(s),
    .boton_abrir(boton_abrir), .boton_cerrar(boton_cerrar), .obstaculo(obstaculo),
    .motor_abrir(motor_abrir), .motor_cerrar(motor_cerrar), .esperar(esperar),
    .limpiar(limpiar), .falla(falla)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn;
    logic [3:0] est;
    logic [9:0] s;
    logic       ab, ce, ob;
    logic       ma, mc, esp;
    logic [9:0] lim;
    logic       fa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic rn, input logic [3:0] est, input logic [9:0] sv,
                     input logic ab, input logic ce, input logic ob,
                     input logic ma, input logic mc, input logic esp,
                     input logic [9:0] lim, input logic fa);
    vec_t v;
    v.rn = rn; v.est = est; v.s = sv; v.ab = ab; v.ce = ce; v.ob = ob;
    v.ma = ma; v.mc = mc; v.esp = esp; v.lim = lim; v.fa = fa;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks n consecutive cycles with the inputs currently applied.
  task automatic run(input string nm, input int n, input logic ma, input logic mc,
                     input logic esp, input logic fa);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({nm, ".motor_abrir"}, {9'b0, motor_abrir}, {9'b0, ma});
      chk({nm, ".motor_cerrar"}, {9'b0, motor_cerrar}, {9'b0, mc});
      chk({nm, ".esperar"}, {9'b0, esperar}, {9'b0, esp});
      chk({nm, ".falla"}, {9'b0, falla}, {9'b0, fa});
      chk({nm, ".limpiar"}, limpiar, 10'h000);
      next_cycle();
    end
  endtask

  initial begin
    // Reset closing: 3 cycles of CERRANDO, then CERRADA.
    add(3, 1, 4'b0000, 10'h000, 0,0,0, 0,1,1, 10'h000, 0);
    add(1, 1, 4'b0000, 10'h000, 0,0,0, 0,0,0, 10'h000, 0);
    // Floor 2 cabin call; register clears s[7] after the limpiar cycle.
    // The still-pending request in the first open cycle extends the hold: 1+5.
    add(1, 1, 4'b0001, 10'h080, 0,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0001, 10'h080, 0,0,0, 1,0,1, 10'h000, 0);
    add(1, 1, 4'b0001, 10'h080, 0,0,0, 0,0,1, 10'h080, 0);
    add(5, 1, 4'b0001, 10'h000, 0,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0001, 10'h000, 0,0,0, 0,1,1, 10'h000, 0);
    add(1, 1, 4'b0001, 10'h000, 0,0,0, 0,0,0, 10'h000, 0);
    // Open button pulse only: plain 3 / 5 / 3 cycle.
    add(1, 1, 4'b0001, 10'h000, 1,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0001, 10'h000, 0,0,0, 1,0,1, 10'h000, 0);
    add(5, 1, 4'b0001, 10'h000, 0,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0001, 10'h000, 0,0,0, 0,1,1, 10'h000, 0);
    add(1, 1, 4'b0001, 10'h000, 0,0,0, 0,0,0, 10'h000, 0);
    // Floor 4 with a floor-1 call pending: only floor-4 bits cleared.
    add(1, 1, 4'b0011, 10'h221, 0,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0011, 10'h221, 0,0,0, 1,0,1, 10'h000, 0);
    add(1, 1, 4'b0011, 10'h221, 0,0,0, 0,0,1, 10'h220, 0);
    add(5, 1, 4'b0011, 10'h001, 0,0,0, 0,0,1, 10'h000, 0);
    add(3, 1, 4'b0011, 10'h001, 0,0,0, 0,1,1, 10'h000, 0);
    add(1, 1, 4'b0011, 10'h001, 0,0,0, 0,0,0, 10'h000, 0);

    reset_n = 1'b0; estado = 4'b0000; s = 10'h000;
    boton_abrir = 1'b0; boton_cerrar = 1'b0; obstaculo = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      reset_n = tbl[i].rn; estado = tbl[i].est; s = tbl[i].s;
      boton_abrir = tbl[i].ab; boton_cerrar = tbl[i].ce; obstaculo = tbl[i].ob;
      #1;
      chk($sformatf("vec%0d.motor_abrir", i), {9'b0, motor_abrir}, {9'b0, tbl[i].ma});
      chk($sformatf("vec%0d.motor_cerrar", i), {9'b0, motor_cerrar}, {9'b0, tbl[i].mc});
      chk($sformatf("vec%0d.esperar", i), {9'b0, esperar}, {9'b0, tbl[i].esp});
      chk($sformatf("vec%0d.limpiar", i), limpiar, tbl[i].lim);
      chk($sformatf("vec%0d.falla", i), {9'b0, falla}, {9'b0, tbl[i].fa});
      next_cycle();
    end

    // Obstacle on 4th open cycle restarts the hold: 9 open cycles.
    estado = 4'b0001; s = 10'h000;
    boton_abrir = 1'b1; run("obs_open", 1, 0, 0, 1, 0);
    boton_abrir = 1'b0; run("obs_abriendo", 3, 1, 0, 1, 0);
    run("obs_abierta_a", 3, 0, 0, 1, 0);
    obstaculo = 1'b1; run("obs_pulse", 1, 0, 0, 1, 0);
    obstaculo = 1'b0; run("obs_abierta_b", 5, 0, 0, 1, 0);
    // Obstacle in CERRANDO cycle 2: full reopen.
    run("obs_cerr1", 1, 0, 1, 1, 0);
    obstaculo = 1'b1; run("obs_cerr2", 1, 0, 1, 1, 0);
    obstaculo = 1'b0; run("reopen_abriendo", 3, 1, 0, 1, 0);
    // Close button with obstacle: reload wins; close alone then closes.
    obstaculo = 1'b1; boton_cerrar = 1'b1; run("cerrar_obs", 1, 0, 0, 1, 0);
    obstaculo = 1'b0; run("cerrar_solo", 1, 0, 0, 1, 0);
    boton_cerrar = 1'b0; run("cerrando_a", 2, 0, 1, 1, 0);
    // Obstacle at the last closing cycle: reopen wins.
    obstaculo = 1'b1; run("obs_t0", 1, 0, 1, 1, 0);
    obstaculo = 1'b0; run("t0_abriendo", 3, 1, 0, 1, 0);
    run("t0_abierta", 5, 0, 0, 1, 0);
    run("t0_cerrando", 3, 0, 1, 1, 0);
    run("t0_cerrada", 1, 0, 0, 0, 0);

    // Moving car never opens, even with open button and floor request.
    estado = 4'b1100; s = 10'h040; boton_abrir = 1'b1;
    run("moving", 4, 0, 0, 0, 0);
    s = 10'h000; boton_abrir = 1'b0;

    // Car starts moving while open: sticky fault until reset.
    estado = 4'b0001;
    boton_abrir = 1'b1; run("f_open", 1, 0, 0, 1, 0);
    boton_abrir = 1'b0; run("f_abriendo", 3, 1, 0, 1, 0);
    estado = 4'b1001; run("f_set", 1, 0, 0, 1, 0);
    run("f_abierta", 4, 0, 0, 1, 1);
    run("f_cerrando", 3, 0, 1, 1, 1);
    run("f_cerrada", 2, 0, 0, 0, 1);
    estado = 4'b0001; reset_n = 1'b0; run("f_rst", 1, 0, 0, 0, 1);
    reset_n = 1'b1; run("f_after_rst", 3, 0, 1, 1, 0);
    run("f_closed", 1, 0, 0, 0, 0);

    // Reset mid-open drives the door closed.
    boton_abrir = 1'b1; run("r_open", 1, 0, 0, 1, 0);
    boton_abrir = 1'b0; run("r_abriendo", 1, 1, 0, 1, 0);
    reset_n = 1'b0; run("r_assert", 1, 1, 0, 1, 0);
    reset_n = 1'b1; run("r_closing", 3, 0, 1, 1, 0);
    run("r_closed", 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
